// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, stability-qualified debouncer with edge strobes and bounce counter
module btn_debounce #(
    parameter int STABLE_CYCLES = 2_000_000,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                btn_raw,
    output logic                btn_db,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);

    localparam logic [1:0] ST_LOW   = 2'd0;
    localparam logic [1:0] CHK_HIGH = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] CHK_LOW  = 2'd3;

    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    logic                sync1_q, sync2_q;
    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                db_q, db_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                glitch_hit;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        glitch_hit = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (sync2_q) begin
                    state_d = CHK_HIGH;
                    cnt_d   = '0;
                end
            end
            CHK_HIGH: begin
                if (!sync2_q) begin
                    state_d    = ST_LOW;
                    cnt_d      = '0;
                    glitch_hit = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HIGH: begin
                if (!sync2_q) begin
                    state_d = CHK_LOW;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (sync2_q) begin
                    state_d    = ST_HIGH;
                    cnt_d      = '0;
                    glitch_hit = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
        // Level follows the next state so btn_db and its strobe change on the same edge.
        db_d     = (state_d == ST_HIGH) || (state_d == CHK_LOW);
        glitch_d = (glitch_hit && (glitch_q != GLITCH_MAX)) ? glitch_q + 1'b1 : glitch_q;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= ST_LOW;
            cnt_q    <= '0;
            db_q     <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign btn_db     = db_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - directed bench with pulse scoreboard for btn_debounce
module tb_btn_debounce;

    localparam int SC = 4;
    localparam int GW = 8;

    typedef struct {
        bit is_rise;
        int cyc;
    } pulse_t;

    logic          clk_in = 1'b0;
    logic          rst    = 1'b1;
    logic          btn_raw = 1'b0;
    logic          btn_db, rise_pulse, fall_pulse;
    logic [GW-1:0] glitch_cnt;

    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     glitch_exp = 0;
    pulse_t exp_q[$];

    btn_debounce #(.STABLE_CYCLES(SC), .GLITCH_W(GW)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_db     (btn_db),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        pulse_t ev;
        checks++;
        assert (!(rise_pulse && fall_pulse)) else begin
            errors++;
            $error("FAIL pulse_excl observed rise=%0b fall=%0b expected not both", rise_pulse, fall_pulse);
        end
        if (rise_pulse || fall_pulse) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_pulse observed rise=%0b fall=%0b at cyc=%0d expected none", rise_pulse, fall_pulse, cyc);
            end
            if (exp_q.size() != 0) begin
                ev = exp_q.pop_front();
                checks++;
                assert (rise_pulse === ev.is_rise && fall_pulse === !ev.is_rise && cyc === ev.cyc) else begin
                    errors++;
                    $error("FAIL pulse_match observed rise=%0b fall=%0b cyc=%0d expected rise=%0b cyc=%0d",
                           rise_pulse, fall_pulse, cyc, ev.is_rise, ev.cyc);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk_in);
    endtask

    // Drive a clean new level; edge 1 is the next posedge, strobe lands after edge 1+SC+2.
    task automatic qualify(input bit lvl, input string tag);
        int e1;
        pulse_t ev;
        @(negedge clk_in);
        btn_raw = lvl;
        e1 = cyc + 1;
        ev.is_rise = lvl;
        ev.cyc = e1 + SC + 2;
        exp_q.push_back(ev);
        wait_cyc(e1 + SC + 1);
        chk({tag, "_db_before"}, 32'(btn_db), 32'(!lvl));
        @(negedge clk_in);
        chk({tag, "_db_after"}, 32'(btn_db), 32'(lvl));
        @(negedge clk_in);
        chk({tag, "_db_hold"}, 32'(btn_db), 32'(lvl));
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_glitch"}, 32'(glitch_cnt), glitch_exp);
    endtask

    initial begin
        bit pat[5];
        int e0;
        int e1;
        pulse_t ev;

        // Reset held while the raw input toggles.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            btn_raw = ~btn_raw;
            chk("reset_active_outs", 32'({btn_db, rise_pulse, fall_pulse, glitch_cnt}), 0);
        end
        @(negedge clk_in);
        btn_raw = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            chk("post_reset_outs", 32'({btn_db, rise_pulse, fall_pulse, glitch_cnt}), 0);
        end

        qualify(1'b1, "clean_press");
        repeat (5) @(negedge clk_in);
        qualify(1'b0, "clean_release");
        repeat (5) @(negedge clk_in);

        // Bounce 1,0,1,1,0 then hold high: two aborted attempts, one rise.
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clk_in);
        btn_raw = pat[0];
        e0 = cyc + 1;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk_in);
            btn_raw = pat[i];
        end
        @(negedge clk_in);
        btn_raw = 1'b1;
        ev.is_rise = 1'b1;
        ev.cyc = e0 + 5 + SC + 2;
        exp_q.push_back(ev);
        glitch_exp = 2;
        wait_cyc(e0 + 5 + SC + 1);
        chk("bounce_db_before", 32'(btn_db), 0);
        @(negedge clk_in);
        chk("bounce_db_after", 32'(btn_db), 1);
        @(negedge clk_in);
        chk("bounce_glitch", 32'(glitch_cnt), glitch_exp);
        chk("bounce_queue_empty", exp_q.size(), 0);

        qualify(1'b0, "bounce_release");
        repeat (5) @(negedge clk_in);

        // Isolated single-cycle highs: each one aborts a qualification.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_in);
            btn_raw = 1'b1;
            @(negedge clk_in);
            btn_raw = 1'b0;
        end
        repeat (8) @(negedge clk_in);
        glitch_exp = (glitch_exp + 300 > 255) ? 255 : glitch_exp + 300;
        chk("sat_glitch", 32'(glitch_cnt), glitch_exp);
        chk("sat_db", 32'(btn_db), 0);
        chk("sat_queue_empty", exp_q.size(), 0);

        // Reset while CHK_HIGH holds cnt = 2, then requalify from scratch.
        @(negedge clk_in);
        btn_raw = 1'b1;
        e1 = cyc + 1;
        wait_cyc(e1 + 4);
        rst = 1'b1;
        #1;
        chk("midq_reset_outs", 32'({btn_db, rise_pulse, fall_pulse, glitch_cnt}), 0);
        @(negedge clk_in);
        chk("midq_reset_hold", 32'({btn_db, rise_pulse, fall_pulse, glitch_cnt}), 0);
        rst = 1'b0;
        glitch_exp = 0;
        e1 = cyc + 1;
        ev.is_rise = 1'b1;
        ev.cyc = e1 + SC + 2;
        exp_q.push_back(ev);
        wait_cyc(e1 + SC + 1);
        chk("midq_db_before", 32'(btn_db), 0);
        @(negedge clk_in);
        chk("midq_db_after", 32'(btn_db), 1);
        @(negedge clk_in);
        chk("midq_glitch", 32'(glitch_cnt), 0);
        chk("midq_queue_empty", exp_q.size(), 0);

        // Long constant high: no further activity.
        repeat (40) @(negedge clk_in);
        chk("const_db", 32'(btn_db), 1);
        chk("const_glitch", 32'(glitch_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Input-conditioning stage that cleans a raw, bouncing, asynchronous push-button/switch level.
- Its outputs directly drive the data input of the 5 Hz divided-clock flip-flop stage.
- Runs on the fast board clock (100 MHz nominal).
- Provides a two-flop synchronizer, a stability-qualified debounced level, single-cycle edge strobes, and a saturating bounce counter for lab diagnostics.

Parameters:
- STABLE_CYCLES, 2_000_000: consecutive synchronized samples required to accept a new level (20 ms at 100 MHz). Legal minimum is 2. Benches use 4.
- GLITCH_W, 8: width of the saturating bounce counter.

Ports:
- clk_in  input  1  fast system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_raw  input  1  raw asynchronous button level.
- btn_db  output  1  debounced level; feeds d of the 5 Hz flip-flop stage.
- rise_pulse  output  1  one-cycle strobe when btn_db goes 0->1.
- fall_pulse  output  1  one-cycle strobe when btn_db goes 1->0.
- glitch_cnt  output  GLITCH_W  count of aborted qualification attempts; saturating.

Behaviour:
- Reset:
  - Asserting rst immediately forces sync1 = sync2 = 0, state = STABLE_LOW, cnt = 0, btn_db = 0, rise_pulse = 0, fall_pulse = 0, glitch_cnt = 0.
  - Asserting rst mid-qualification abandons the attempt with no pulse.
  - Deassertion takes effect at the next rising edge.
- Synchronizer:
  - sync1 <= btn_raw; sync2 <= sync1.
  - Only sync2 is used downstream; btn_raw is never used combinationally.
- Counter: cnt is ceil(log2(STABLE_CYCLES)) bits and is cleared on every state entry.
- State machine (4 states, registered):
  - STABLE_LOW: btn_db = 0. If sync2 == 1, go to CHK_HIGH with cnt = 0; else stay.
  - CHK_HIGH: btn_db = 0.
    - If sync2 == 0: go to STABLE_LOW and increment glitch_cnt.
    - Else if cnt == STABLE_CYCLES-1: go to STABLE_HIGH and assert rise_pulse for exactly that one cycle.
    - Else cnt++.
  - STABLE_HIGH: btn_db = 1. If sync2 == 0, go to CHK_LOW with cnt = 0.
  - CHK_LOW: btn_db = 1.
    - If sync2 == 1: go to STABLE_HIGH and increment glitch_cnt.
    - Else if cnt == STABLE_CYCLES-1: go to STABLE_LOW and assert fall_pulse for one cycle.
    - Else cnt++.
- Latency:
  - Let edge 1 be the first rising edge that samples a clean new btn_raw level.
  - btn_db changes after edge STABLE_CYCLES+3: 2 synchronizer edges, 1 entry edge, STABLE_CYCLES qualification edges.
  - The matching pulse is high for exactly that same cycle.
- Outputs: btn_db, rise_pulse, fall_pulse and glitch_cnt are registered; no combinational path from any input.
- Mutual exclusion: rise_pulse and fall_pulse are never high together. Neither fires without a btn_db change.
- Glitch accounting: glitch_cnt saturates at 2^GLITCH_W-1 and does not wrap. It is cleared only by rst.
- Pulses per transition: a level that returns before qualification completes produces no btn_db change and no pulse. Any single qualified transition produces exactly one pulse.
- Constant input: btn_raw held constant for arbitrarily long causes no state change beyond the first qualification. cnt never exceeds STABLE_CYCLES-1.

Test Plan (STABLE_CYCLES = 4, clk_in period 10 ns):
- Reset during activity:
  - Stimulus: rst = 1 while btn_raw toggles.
  - Response: btn_db = 0, pulses = 0, glitch_cnt = 0 throughout. After release with btn_raw = 0, all outputs stay 0.
- Clean press:
  - Stimulus: btn_raw 0->1 sampled at edge 1 and held.
  - Response: btn_db = 1 after edge 7; rise_pulse high for exactly the cycle after edge 7; glitch_cnt = 0.
- Clean release:
  - Stimulus: from the debounced-high state, btn_raw 1->0 and held.
  - Response: btn_db = 0 after edge 7 of the release; single fall_pulse; no rise_pulse.
- Bounce:
  - Stimulus: btn_raw pattern 1,0,1,1,0 (one edge each), then held 1.
  - Response: glitch_cnt = 2; exactly one rise_pulse; btn_db = 1 once 4 consecutive synchronized highs are seen.
- Saturation:
  - Stimulus: 300 isolated one-cycle high glitches with GLITCH_W = 8.
  - Response: glitch_cnt = 255; btn_db remains 0; no pulses.
- Reset mid-qualification:
  - Stimulus: assert rst during CHK_HIGH (cnt = 2), then release with btn_raw still 1.
  - Response: btn_db stays 0 until a full fresh 7-edge qualification completes; glitch_cnt = 0; exactly one rise_pulse.
